// File: rtl/wb_pkg.sv
// Shared types for the writeback sequencer: mux source encoding, FSM states,
// and the source legality check used when a request is accepted.
package wb_pkg;

    typedef enum logic [2:0] {
        WB_ALU   = 3'd0,
        WB_MEM   = 3'd1,
        WB_IMM   = 3'd2,
        WB_SHIFT = 3'd3,
        WB_PC4   = 3'd4,
        WB_FLAG  = 3'd5
    } wb_src_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2,
        ERR      = 2'd3
    } wb_state_e;

    localparam logic [2:0] WB_SEL_IDLE = 3'd0;

    // Selects 6 and 7 have no mux input behind them.
    function automatic logic is_legal_src(input logic [2:0] src);
        return (src <= 3'(WB_FLAG));
    endfunction

endpackage

// File: rtl/wb_timeout_timer.sv
// Clear/enable up-counter that flags the last allowed cycle of a memory wait.
// expire is high while the count sits at MEM_TIMEOUT-1.
module wb_timeout_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] count;

    assign expire = (count == TW'(MEM_TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one request at a time, waits for load data on
// memory-sourced writes, and drives the register-file write port and mux select.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       issue_src,
    input  logic [4:0]       issue_rd,
    input  logic             issue_wen,
    input  logic             mem_done,
    output logic [2:0]       wb_sel,
    output logic             rf_wen,
    output logic [4:0]       rf_rd,
    output logic             wb_err,
    output logic             err_sticky,
    input  logic             err_clear,
    output logic [CNT_W-1:0] retired_count
);

    wb_state_e  state;
    logic [2:0] src_q;
    logic [4:0] rd_q;
    logic       wen_q;
    logic       timer_expire;

    // Timer is held at zero everywhere except WAIT_MEM, so each wait starts fresh.
    wb_timeout_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != WAIT_MEM),
        .enable (state == WAIT_MEM),
        .expire (timer_expire)
    );

    // Outputs are assigned on the edge that enters each state, so they are
    // valid for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            src_q         <= WB_SEL_IDLE;
            rd_q          <= '0;
            wen_q         <= 1'b0;
            issue_ready   <= 1'b1;
            wb_sel        <= WB_SEL_IDLE;
            rf_wen        <= 1'b0;
            rf_rd         <= '0;
            wb_err        <= 1'b0;
            err_sticky    <= 1'b0;
            retired_count <= '0;
        end else begin
            rf_wen <= 1'b0;
            wb_err <= 1'b0;
            // A pulse in flight (or being raised below) overrides the clear.
            if (err_clear && !wb_err) begin
                err_sticky <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    wb_sel <= WB_SEL_IDLE;
                    if (issue_valid) begin
                        src_q       <= issue_src;
                        rd_q        <= issue_rd;
                        wen_q       <= issue_wen;
                        issue_ready <= 1'b0;
                        if (issue_src == 3'(WB_MEM)) begin
                            state  <= WAIT_MEM;
                            wb_sel <= 3'(WB_MEM);
                        end else if (is_legal_src(issue_src)) begin
                            state         <= COMMIT;
                            wb_sel        <= issue_src;
                            rf_rd         <= issue_rd;
                            rf_wen        <= issue_wen && (issue_rd != 5'd0);
                            retired_count <= retired_count + CNT_W'(1);
                        end else begin
                            state      <= ERR;
                            wb_err     <= 1'b1;
                            err_sticky <= 1'b1;
                        end
                    end
                end

                WAIT_MEM: begin
                    if (mem_done) begin
                        state         <= COMMIT;
                        wb_sel        <= src_q;
                        rf_rd         <= rd_q;
                        rf_wen        <= wen_q && (rd_q != 5'd0);
                        retired_count <= retired_count + CNT_W'(1);
                    end else if (timer_expire) begin
                        state      <= ERR;
                        wb_sel     <= WB_SEL_IDLE;
                        wb_err     <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end

                COMMIT, ERR: begin
                    state       <= IDLE;
                    wb_sel      <= WB_SEL_IDLE;
                    issue_ready <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    wb_sel      <= WB_SEL_IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
